// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in serial-out transmitter with a valid/ready load handshake.
// A word accepted in the last-bit cycle of the previous word follows it with no gap.
module piso_shifter #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             q,
    output logic             q_valid,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic             q_n, q_valid_n, done_n, load_ready_n, accept;

    assign accept = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            q          <= 1'b0;
            q_valid    <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sr         <= sr_n;
            q          <= q_n;
            q_valid    <= q_valid_n;
            done       <= done_n;
            load_ready <= load_ready_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        sr_n         = sr;
        q_n          = q;
        q_valid_n    = q_valid;
        done_n       = 1'b0;
        load_ready_n = load_ready;
        if (state == IDLE || cnt == LAST) begin
            // idle or last bit: either take a new word or fall back to idle
            if (accept) begin
                state_n      = SHIFT;
                cnt_n        = '0;
                sr_n         = load_data;
                q_n          = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
                q_valid_n    = 1'b1;
                load_ready_n = 1'b0;
            end else begin
                state_n      = IDLE;
                cnt_n        = '0;
                q_n          = 1'b0;
                q_valid_n    = 1'b0;
                load_ready_n = 1'b1;
            end
        end else begin
            cnt_n        = cnt + CW'(1);
            sr_n         = (MSB_FIRST != 0) ? sr << 1 : sr >> 1;
            q_n          = (MSB_FIRST != 0) ? sr[WIDTH-2] : sr[1];
            done_n       = (cnt_n == LAST);
            load_ready_n = (cnt_n == LAST);
        end
    end
endmodule

// File: tb/tb_piso_shifter.sv
// tb_piso_shifter: directed and random stimulus on MSB-first and LSB-first instances,
// checked against a queue-of-expected-cycles reference model.
module tb_piso_shifter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       m_ready, m_q, m_qv, m_done;
    logic       l_ready, l_q, l_qv, l_done;

    int checks = 0;
    int failures = 0;

    logic [2:0] qm[$];
    logic [2:0] ql[$];
    logic [2:0] cur_m = '0;
    logic [2:0] cur_l = '0;
    logic       exp_ready = 1'b0;

    always #10 clk = ~clk;

    piso_shifter #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(m_ready),
        .load_data(load_data), .q(m_q), .q_valid(m_qv), .done(m_done)
    );

    piso_shifter #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(l_ready),
        .load_data(load_data), .q(l_q), .q_valid(l_qv), .done(l_done)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at %0t: ready/done/q_valid/q got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_both(input string tag);
        chk({tag, "_msb"}, {m_ready, m_done, m_qv, m_q}, {exp_ready, cur_m});
        chk({tag, "_lsb"}, {l_ready, l_done, l_qv, l_q}, {exp_ready, cur_l});
    endtask

    // Model: an accepted word appends WIDTH future output cycles {done,q_valid,q};
    // ready is high whenever no further cycles are pending.
    task automatic step(input string tag, input logic lv, input logic [7:0] ld);
        load_valid = lv;
        load_data  = ld;
        @(posedge clk);
        if (rst_n) begin
            if (lv && exp_ready) begin
                for (int i = 0; i < 8; i++) begin
                    qm.push_back({i == 7, 1'b1, ld[7-i]});
                    ql.push_back({i == 7, 1'b1, ld[i]});
                end
            end
            cur_m     = (qm.size() != 0) ? qm.pop_front() : 3'b000;
            cur_l     = (ql.size() != 0) ? ql.pop_front() : 3'b000;
            exp_ready = (qm.size() == 0);
        end
        @(negedge clk);
        check_both(tag);
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 8'($urandom));
    endtask

    task automatic async_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        qm.delete();
        ql.delete();
        cur_m     = '0;
        cur_l     = '0;
        exp_ready = 1'b0;
        check_both({tag, "_imm"});
        @(negedge clk);
        check_both({tag, "_hold"});
        rst_n = 1'b1;
    endtask

    initial begin
        step("in_reset", 1'b0, 8'h00);
        step("in_reset", 1'b1, 8'h55);
        rst_n = 1'b1;
        idle_steps("release", 3);

        step("a5_accept", 1'b1, 8'hA5);
        idle_steps("a5_shift", 10);

        step("b2b_ff", 1'b1, 8'hFF);
        for (int i = 0; i < 8; i++) step("b2b_00", 1'b1, 8'h00);
        idle_steps("b2b_tail", 10);

        step("busy_first", 1'b1, 8'($urandom));
        for (int i = 0; i < 8; i++) step("busy_3c", 1'b1, 8'h3C);
        idle_steps("busy_tail", 10);

        step("rst_f0", 1'b1, 8'hF0);
        idle_steps("rst_f0_bits", 2);
        async_reset("mid_word_rst");
        idle_steps("post_rst", 2);
        step("word_81", 1'b1, 8'h81);
        idle_steps("word_81_bits", 10);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rand_rst");
            end else begin
                step("random", ($urandom_range(0, 3) != 0), 8'($urandom));
            end
        end
        idle_steps("drain", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
